// File: rtl/sound_unpacker_if.sv
// Byte-stream and sample-output bundle of the sound unpacker.
// master = byte router / sample consumer side, slave = sound_unpacker.
interface sound_unpacker_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        sound_write_ready;
    logic        sound_write;
    logic [15:0] sound_l;
    logic [15:0] sound_r;

    modport master (
        output byte_valid,
        output byte_data,
        output sound_write_ready,
        input  byte_ready,
        input  sound_write,
        input  sound_l,
        input  sound_r
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  sound_write_ready,
        output byte_ready,
        output sound_write,
        output sound_l,
        output sound_r
    );
endinterface

// File: rtl/sound_unpacker.sv
// Unpacks 16-bit LE PCM payload bytes into sound_write strobes (mono/stereo, drain mode).
// Optional SOUND_UNPACK_ATTEN_EN adds sound_atten: per-block arithmetic right shift of samples.
//
// state   | meaning
// IDLE    | waiting for blk_start with a non-zero byte count
// COLLECT | accepting bytes of the current frame
// PUSH    | frame complete, waiting for sound_write_ready to emit it
// DRAIN   | chan 0: accepting and discarding the remaining block bytes
module sound_unpacker #(
    parameter int LEN_W = 16
) (
    input  logic             clk_sys,
    input  logic             sound_reset_n,
    input  logic [1:0]       sound_chan,
    input  logic             blk_start,
    input  logic [LEN_W-1:0] blk_bytes,
`ifdef SOUND_UNPACK_ATTEN_EN
    input  logic [2:0]       sound_atten,
`endif
    sound_unpacker_if.slave  snd,
    output logic             busy,
    output logic             blk_err,
    output logic [LEN_W-1:0] samples_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PUSH    = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]       state;
    logic             stereo_q;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       idx;
    logic [3:0][7:0]  frame_buf;
    logic             sound_write_q;
    logic [15:0]      sound_l_q;
    logic [15:0]      sound_r_q;
    logic             blk_err_q;

    logic             accept;
    logic [1:0]       last_idx;
    logic [LEN_W-1:0] rem_dec;
    logic signed [15:0] samp_l_raw;
    logic signed [15:0] samp_r_raw;
    logic signed [15:0] samp_l;
    logic signed [15:0] samp_r;

    assign snd.byte_ready  = (state == ST_COLLECT) || (state == ST_DRAIN);
    assign snd.sound_write = sound_write_q;
    assign snd.sound_l     = sound_l_q;
    assign snd.sound_r     = sound_r_q;
    assign busy            = (state != ST_IDLE);
    assign blk_err         = blk_err_q;

    assign accept   = snd.byte_valid && snd.byte_ready;
    assign last_idx = stereo_q ? 2'd3 : 2'd1;
    // Decrement saturates so the counter can never wrap below zero.
    assign rem_dec  = (remaining != '0) ? (remaining - LEN_W'(1)) : '0;

    assign samp_l_raw = {frame_buf[1], frame_buf[0]};
    assign samp_r_raw = stereo_q ? {frame_buf[3], frame_buf[2]} : samp_l_raw;

`ifdef SOUND_UNPACK_ATTEN_EN
    logic [2:0] atten_q;

    always_ff @(posedge clk_sys or negedge sound_reset_n) begin
        if (!sound_reset_n) begin
            atten_q <= 3'd0;
        end else if (blk_start && (state == ST_IDLE) && (blk_bytes != '0)) begin
            atten_q <= sound_atten;
        end
    end

    assign samp_l = samp_l_raw >>> atten_q;
    assign samp_r = samp_r_raw >>> atten_q;
`else
    assign samp_l = samp_l_raw;
    assign samp_r = samp_r_raw;
`endif

    always_ff @(posedge clk_sys or negedge sound_reset_n) begin
        if (!sound_reset_n) begin
            state         <= ST_IDLE;
            stereo_q      <= 1'b0;
            remaining     <= '0;
            idx           <= 2'd0;
            frame_buf     <= '0;
            sound_write_q <= 1'b0;
            sound_l_q     <= 16'd0;
            sound_r_q     <= 16'd0;
            blk_err_q     <= 1'b0;
            samples_cnt   <= '0;
        end else begin
            sound_write_q <= 1'b0;
            blk_err_q     <= 1'b0;

            if (blk_start && (state != ST_IDLE)) begin
                blk_err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (blk_start && (blk_bytes != '0)) begin
                        stereo_q    <= sound_chan[1];
                        remaining   <= blk_bytes;
                        idx         <= 2'd0;
                        samples_cnt <= '0;
                        state       <= (sound_chan == 2'd0) ? ST_DRAIN : ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (accept) begin
                        frame_buf[idx] <= snd.byte_data;
                        remaining      <= rem_dec;
                        if (idx == last_idx) begin
                            idx   <= 2'd0;
                            state <= ST_PUSH;
                        end else if (rem_dec == '0) begin
                            // Block ended mid-frame: partial frame is dropped.
                            idx       <= 2'd0;
                            blk_err_q <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end

                ST_PUSH: begin
                    if (snd.sound_write_ready) begin
                        sound_write_q <= 1'b1;
                        sound_l_q     <= samp_l;
                        sound_r_q     <= samp_r;
                        samples_cnt   <= samples_cnt + LEN_W'(1);
                        state         <= (remaining != '0) ? ST_COLLECT : ST_IDLE;
                    end
                end

                ST_DRAIN: begin
                    if (accept) begin
                        remaining <= rem_dec;
                        if (rem_dec == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_unpacker.sv
// Directed bench for sound_unpacker: stereo/mono unpacking, latency, backpressure,
// truncation, drain mode, busy blk_start, async reset (plus attenuation when enabled).
module tb_sound_unpacker;
    localparam int LEN_W = 16;

    logic             clk_sys = 1'b0;
    logic             sound_reset_n;
    logic [1:0]       sound_chan;
    logic             blk_start;
    logic [LEN_W-1:0] blk_bytes;
`ifdef SOUND_UNPACK_ATTEN_EN
    logic [2:0]       sound_atten;
`endif
    logic             busy;
    logic             blk_err;
    logic [LEN_W-1:0] samples_cnt;

    sound_unpacker_if snd();

    sound_unpacker #(.LEN_W(LEN_W)) dut (
        .clk_sys       (clk_sys),
        .sound_reset_n (sound_reset_n),
        .sound_chan    (sound_chan),
        .blk_start     (blk_start),
        .blk_bytes     (blk_bytes),
`ifdef SOUND_UNPACK_ATTEN_EN
        .sound_atten   (sound_atten),
`endif
        .snd           (snd),
        .busy          (busy),
        .blk_err       (blk_err),
        .samples_cnt   (samples_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    int          q_cyc[$];
    int          err_cnt = 0;
    int          err_cyc = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cycle++;

    always @(negedge clk_sys) begin
        if (snd.sound_write === 1'b1) begin
            q_l.push_back(snd.sound_l);
            q_r.push_back(snd.sound_r);
            q_cyc.push_back(cycle);
        end
        if (blk_err === 1'b1) begin
            err_cnt++;
            err_cyc = cycle;
        end
    end

    task automatic clear_mon();
        q_l.delete();
        q_r.delete();
        q_cyc.delete();
        err_cnt = 0;
        err_cyc = 0;
    endtask

    task automatic start_block(input logic [1:0] chan, input logic [LEN_W-1:0] n);
        sound_chan = chan;
        blk_bytes  = n;
        blk_start  = 1'b1;
        @(negedge clk_sys);
        blk_start  = 1'b0;
    endtask

    // Offers one byte and returns the cycle count just before the accepting edge.
    task automatic send_byte(input logic [7:0] d, output int acc_cyc);
        int t;
        t = 0;
        snd.byte_valid = 1'b1;
        snd.byte_data  = d;
        while (snd.byte_ready !== 1'b1 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout data=%h waited=%0d required<200", d, t);
        end
        acc_cyc = cycle;
        @(negedge clk_sys);
        snd.byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
        end
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        sound_reset_n = 1'b0;
        sound_chan = 2'd0;
        blk_start = 1'b0;
        blk_bytes = '0;
`ifdef SOUND_UNPACK_ATTEN_EN
        sound_atten = 3'd0;
`endif
        snd.byte_valid = 1'b0;
        snd.byte_data = 8'h00;
        snd.sound_write_ready = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++; if (snd.byte_ready !== 1'b0) begin errors++; $display("FAIL rst_byte_ready got %b exp 0", snd.byte_ready); end
        checks++; if (snd.sound_write !== 1'b0) begin errors++; $display("FAIL rst_sound_write got %b exp 0", snd.sound_write); end
        checks++; if (snd.sound_l !== 16'h0000 || snd.sound_r !== 16'h0000) begin errors++; $display("FAIL rst_samples got %h/%h exp 0000/0000", snd.sound_l, snd.sound_r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (blk_err !== 1'b0) begin errors++; $display("FAIL rst_blk_err got %b exp 0", blk_err); end
        checks++; if (samples_cnt !== 16'd0) begin errors++; $display("FAIL rst_samples_cnt got %0d exp 0", samples_cnt); end
        sound_reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_stereo();
        logic [7:0] bytes_v [8];
        int acc;
        bytes_v = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        clear_mon();
        start_block(2'd2, 16'd8);
        for (int i = 0; i < 8; i++) send_byte(bytes_v[i], acc);
        wait_idle("stereo");
        checks++; if (q_l.size() !== 2) begin errors++; $display("FAIL stereo_strobes got %0d exp 2", q_l.size()); end
        checks++; if (q_l[0] !== 16'h1234 || q_r[0] !== 16'h5678) begin errors++; $display("FAIL stereo_s0 got %h/%h exp 1234/5678", q_l[0], q_r[0]); end
        checks++; if (q_l[1] !== 16'h9ABC || q_r[1] !== 16'hDEF0) begin errors++; $display("FAIL stereo_s1 got %h/%h exp 9abc/def0", q_l[1], q_r[1]); end
        checks++; if (q_cyc[1] - q_cyc[0] !== 5) begin errors++; $display("FAIL stereo_spacing got %0d exp 5", q_cyc[1] - q_cyc[0]); end
        checks++; if (samples_cnt !== 16'd2) begin errors++; $display("FAIL stereo_cnt got %0d exp 2", samples_cnt); end
        checks++; if (busy !== 1'b0 || err_cnt !== 0) begin errors++; $display("FAIL stereo_end busy=%b errs=%0d exp 0/0", busy, err_cnt); end
    endtask

    task automatic test_mono_latency();
        logic [7:0] bytes_v [4];
        int acc;
        bytes_v = '{8'h01, 8'h80, 8'hFF, 8'h7F};
        clear_mon();
        start_block(2'd1, 16'd4);
        for (int i = 0; i < 4; i++) send_byte(bytes_v[i], acc);
        wait_idle("mono");
        checks++; if (q_l.size() !== 2) begin errors++; $display("FAIL mono_strobes got %0d exp 2", q_l.size()); end
        checks++; if (q_l[0] !== 16'h8001 || q_r[0] !== 16'h8001) begin errors++; $display("FAIL mono_s0 got %h/%h exp 8001/8001", q_l[0], q_r[0]); end
        checks++; if (q_l[1] !== 16'h7FFF || q_r[1] !== 16'h7FFF) begin errors++; $display("FAIL mono_s1 got %h/%h exp 7fff/7fff", q_l[1], q_r[1]); end
        checks++; if (q_cyc[1] - acc !== 2) begin errors++; $display("FAIL mono_latency got %0d exp 2", q_cyc[1] - acc); end
        checks++; if (q_cyc[1] - q_cyc[0] !== 3) begin errors++; $display("FAIL mono_spacing got %0d exp 3", q_cyc[1] - q_cyc[0]); end
        checks++; if (samples_cnt !== 16'd2) begin errors++; $display("FAIL mono_cnt got %0d exp 2", samples_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes_v [8];
        int acc;
        int stall_bad;
        int rdy_cyc;
        bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_mon();
        snd.sound_write_ready = 1'b0;
        start_block(2'd3, 16'd8);
        for (int i = 0; i < 4; i++) send_byte(bytes_v[i], acc);
        snd.byte_valid = 1'b1;
        snd.byte_data  = bytes_v[4];
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (snd.byte_ready !== 1'b0 || snd.sound_write !== 1'b0) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_activity got %0d exp 0", stall_bad); end
        checks++; if (q_l.size() !== 0) begin errors++; $display("FAIL bp_no_strobe got %0d exp 0", q_l.size()); end
        checks++; if (snd.sound_l !== 16'h7FFF || snd.sound_r !== 16'h7FFF) begin errors++; $display("FAIL bp_hold got %h/%h exp 7fff/7fff", snd.sound_l, snd.sound_r); end
        rdy_cyc = cycle;
        snd.sound_write_ready = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(bytes_v[i], acc);
        wait_idle("bp");
        checks++; if (q_cyc[0] !== rdy_cyc + 1) begin errors++; $display("FAIL bp_release_latency got %0d exp %0d", q_cyc[0], rdy_cyc + 1); end
        checks++; if (q_l.size() !== 2) begin errors++; $display("FAIL bp_strobes got %0d exp 2", q_l.size()); end
        checks++; if (q_l[0] !== 16'h2211 || q_r[0] !== 16'h4433) begin errors++; $display("FAIL bp_s0 got %h/%h exp 2211/4433", q_l[0], q_r[0]); end
        checks++; if (q_l[1] !== 16'h6655 || q_r[1] !== 16'h8877) begin errors++; $display("FAIL bp_s1 got %h/%h exp 6655/8877", q_l[1], q_r[1]); end
    endtask

    task automatic test_truncated();
        logic [7:0] bytes_v [6];
        int acc;
        bytes_v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        clear_mon();
        start_block(2'd2, 16'd6);
        for (int i = 0; i < 6; i++) send_byte(bytes_v[i], acc);
        wait_idle("trunc");
        checks++; if (q_l.size() !== 1) begin errors++; $display("FAIL trunc_strobes got %0d exp 1", q_l.size()); end
        checks++; if (q_l[0] !== 16'h0201 || q_r[0] !== 16'h0403) begin errors++; $display("FAIL trunc_s0 got %h/%h exp 0201/0403", q_l[0], q_r[0]); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL trunc_err_count got %0d exp 1", err_cnt); end
        checks++; if (err_cyc !== acc + 1) begin errors++; $display("FAIL trunc_err_time got %0d exp %0d", err_cyc, acc + 1); end
        checks++; if (samples_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL trunc_end cnt=%0d busy=%b exp 1/0", samples_cnt, busy); end
    endtask

    task automatic test_drain_and_busy_start();
        int acc;
        clear_mon();
        start_block(2'd2, 16'd0);
        @(negedge clk_sys);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %b exp 0", busy); end
        start_block(2'd0, 16'd5);
        send_byte(8'hA0, acc);
        send_byte(8'hA1, acc);
        sound_chan = 2'd1;
        blk_bytes  = 16'd9;
        blk_start  = 1'b1;
        @(negedge clk_sys);
        blk_start  = 1'b0;
        send_byte(8'hA2, acc);
        send_byte(8'hA3, acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_4 got %b exp 1", busy); end
        send_byte(8'hA4, acc);
        wait_idle("drain");
        snd.byte_valid = 1'b1;
        snd.byte_data  = 8'hA5;
        @(negedge clk_sys);
        checks++; if (snd.byte_ready !== 1'b0) begin errors++; $display("FAIL drain_extra_ready got %b exp 0", snd.byte_ready); end
        snd.byte_valid = 1'b0;
        checks++; if (q_l.size() !== 0) begin errors++; $display("FAIL drain_strobes got %0d exp 0", q_l.size()); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL drain_busy_start_err got %0d exp 1", err_cnt); end
        checks++; if (samples_cnt !== 16'd0) begin errors++; $display("FAIL drain_cnt got %0d exp 0", samples_cnt); end
        checks++; if (snd.sound_l !== 16'h0201 || snd.sound_r !== 16'h0403) begin errors++; $display("FAIL drain_hold got %h/%h exp 0201/0403", snd.sound_l, snd.sound_r); end
    endtask

    task automatic test_reset_mid_collect();
        int acc;
        clear_mon();
        start_block(2'd2, 16'd8);
        send_byte(8'h12, acc);
        send_byte(8'h34, acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        sound_reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || snd.byte_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state busy=%b ready=%b exp 0/0", busy, snd.byte_ready); end
        checks++; if (snd.sound_l !== 16'h0000 || snd.sound_r !== 16'h0000) begin errors++; $display("FAIL rstmid_samples got %h/%h exp 0000/0000", snd.sound_l, snd.sound_r); end
        checks++; if (snd.sound_write !== 1'b0 || blk_err !== 1'b0 || samples_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_flags wr=%b err=%b cnt=%0d exp 0/0/0", snd.sound_write, blk_err, samples_cnt); end
        @(negedge clk_sys);
        sound_reset_n = 1'b1;
        @(negedge clk_sys);
        clear_mon();
        start_block(2'd1, 16'd2);
        send_byte(8'h00, acc);
        send_byte(8'h80, acc);
        wait_idle("rstmid");
        checks++; if (q_l.size() !== 1 || q_l[0] !== 16'h8000 || q_r[0] !== 16'h8000) begin errors++; $display("FAIL rstmid_after n=%0d got %h/%h exp 1 8000/8000", q_l.size(), q_l[0], q_r[0]); end
    endtask

`ifdef SOUND_UNPACK_ATTEN_EN
    task automatic test_atten();
        int acc;
        clear_mon();
        sound_atten = 3'd2;
        start_block(2'd1, 16'd2);
        sound_atten = 3'd0;
        send_byte(8'h00, acc);
        send_byte(8'h80, acc);
        wait_idle("atten");
        checks++; if (q_l.size() !== 1 || q_l[0] !== 16'hE000 || q_r[0] !== 16'hE000) begin errors++; $display("FAIL atten_s0 n=%0d got %h/%h exp 1 e000/e000", q_l.size(), q_l[0], q_r[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_stereo();
        test_mono_latency();
        test_backpressure();
        test_truncated();
        test_drain_and_busy_start();
        test_reset_mid_collect();
`ifdef SOUND_UNPACK_ATTEN_EN
        test_atten();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
